// File: rtl/sodor_dmem_pkg.sv
// Shared types and constants for the Sodor data-memory arbiter.
// The request record is latched once per accepted transaction.
package sodor_dmem_pkg;

    localparam int NUM_WORDS = 16;
    localparam int IDX_W     = 4;
    localparam int DATA_W    = 32;
    localparam int MASK_W    = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]       addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } dmem_req_t;

endpackage

// File: rtl/sodor_rr_arb2.sv
// Two-way round-robin grant. The pointer names the preferred requester when both
// are valid and moves to the non-granted side on every accept.
module sodor_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1,
    output logic accept,
    output logic gnt_id
);

    logic ptr_q;

    // A lone valid requester always wins; the pointer only breaks ties.
    always_comb begin
        gnt_id = ptr_q;
        if (valid0 && !valid1) begin
            gnt_id = 1'b0;
        end else if (valid1 && !valid0) begin
            gnt_id = 1'b1;
        end
    end

    assign ready0 = en && valid0 && !gnt_id;
    assign ready1 = en && valid1 && gnt_id;
    assign accept = ready0 || ready1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~gnt_id;
        end
    end

endmodule

// File: rtl/sodor_dmem_arbiter.sv
// Shares the single-port Sodor dmem between the core (id 0) and the debug port (id 1).
// One transaction in flight: accept, issue to memory, respond, back to idle.
module sodor_dmem_arbiter
    import sodor_dmem_pkg::*;
#(
    parameter int NUM_WORDS = 16,
    parameter int IDX_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [31:0]         req0_addr,
    input  logic                req0_wen,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic [DATA_W/8-1:0] req0_wmask,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [31:0]         req1_addr,
    input  logic                req1_wen,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic [DATA_W/8-1:0] req1_wmask,
    output logic                resp0_valid,
    output logic [DATA_W-1:0]   resp0_rdata,
    output logic                resp0_err,
    output logic                resp1_valid,
    output logic [DATA_W-1:0]   resp1_rdata,
    output logic                resp1_err,
    output logic                mem_en,
    output logic                mem_wen,
    output logic [IDX_W-1:0]    mem_idx,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output state_t              fsm_state
);

    // Handshake: a request transfers on a cycle where valid && ready; ready is only
    // offered in IDLE to the arbitration winner, and requesters hold their fields
    // while valid && !ready. Responses are single-cycle pulses with no backpressure.

    state_t    state_q, state_d;
    dmem_req_t sel_req, lat_q;
    logic      lat_id_q;
    logic      err_q;
    logic      active_q;
    logic      arb_en, arb_accept, arb_gnt;
    logic      in_range;
    logic      unused_addr_bits;

    // Ready stays low for the first cycle out of reset so every output is 0 during reset.
    assign arb_en = active_q && (state_q == IDLE);

    sodor_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (arb_en),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ready0 (req0_ready),
        .ready1 (req1_ready),
        .accept (arb_accept),
        .gnt_id (arb_gnt)
    );

    always_comb begin
        sel_req = '{addr: req0_addr, wen: req0_wen, wdata: req0_wdata, wmask: req0_wmask};
        if (arb_gnt) begin
            sel_req = '{addr: req1_addr, wen: req1_wen, wdata: req1_wdata, wmask: req1_wmask};
        end
    end

    // In range exactly when every bit above the word index is zero; byte offset ignored.
    assign in_range         = lat_q.addr[31:2] < 30'(NUM_WORDS);
    assign unused_addr_bits = ^lat_q.addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            lat_id_q <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            state_q  <= state_d;
            if (arb_accept) begin
                lat_q    <= sel_req;
                lat_id_q <= arb_gnt;
            end
            if (state_q == ISSUE) begin
                err_q <= !in_range;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_en      = 1'b0;
        mem_wen     = 1'b0;
        mem_idx     = '0;
        mem_wdata   = '0;
        mem_wmask   = '0;
        resp0_valid = 1'b0;
        resp0_rdata = '0;
        resp0_err   = 1'b0;
        resp1_valid = 1'b0;
        resp1_rdata = '0;
        resp1_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_accept) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = RESP;
                if (in_range) begin
                    mem_en    = 1'b1;
                    mem_wen   = lat_q.wen;
                    mem_idx   = lat_q.addr[IDX_W+1:2];
                    mem_wdata = lat_q.wdata;
                    mem_wmask = lat_q.wmask;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (lat_id_q) begin
                    resp1_valid = 1'b1;
                    resp1_err   = err_q;
                    resp1_rdata = (!lat_q.wen && !err_q) ? mem_rdata : '0;
                end else begin
                    resp0_valid = 1'b1;
                    resp0_err   = err_q;
                    resp0_rdata = (!lat_q.wen && !err_q) ? mem_rdata : '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_sodor_dmem_arbiter.sv
// Bench for sodor_dmem_arbiter: behavioural dmem macro, shadow memory and pointer model,
// directed scenarios followed by randomized mixed traffic.
module tb_sodor_dmem_arbiter;
    import sodor_dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_wen;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_wmask;
    logic        req1_valid, req1_ready, req1_wen;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_wmask;
    logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        mem_en, mem_wen;
    logic [3:0]  mem_idx, mem_wmask;
    logic [31:0] mem_wdata, mem_rdata;
    state_t      fsm_state;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic        preload;
    logic [31:0] mem_array [16];
    logic [31:0] ref_mem [16];
    int          ptr_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sodor_dmem_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_wen    (req0_wen),
        .req0_wdata  (req0_wdata),
        .req0_wmask  (req0_wmask),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_wen    (req1_wen),
        .req1_wdata  (req1_wdata),
        .req1_wmask  (req1_wmask),
        .resp0_valid (resp0_valid),
        .resp0_rdata (resp0_rdata),
        .resp0_err   (resp0_err),
        .resp1_valid (resp1_valid),
        .resp1_rdata (resp1_rdata),
        .resp1_err   (resp1_err),
        .mem_en      (mem_en),
        .mem_wen     (mem_wen),
        .mem_idx     (mem_idx),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_rdata   (mem_rdata),
        .fsm_state   (fsm_state)
    );

    // Single-port dmem macro: byte-masked write, one-cycle synchronous read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem_array[i] <= 32'h1111_1111 * i;
        end else if (mem_en) begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) mem_array[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= mem_array[mem_idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] m);
        if (id == 0) begin
            req0_addr = a; req0_wen = w; req0_wdata = d; req0_wmask = m;
        end else begin
            req1_addr = a; req1_wen = w; req1_wdata = d; req1_wmask = m;
        end
    endtask

    task automatic rand_req(input int id);
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_0040;
        else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        set_req(id, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;
        ptr_m      = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One transaction from a negedge: wait for grant, check issue and response,
    // returning at the negedge of the response cycle.
    task automatic transact(input bit v0, input bit v1, output int win,
                            output int unsigned acc_cyc, output logic [31:0] got);
        int          n;
        int          idx;
        logic [31:0] a, d, exp_rd;
        logic        w, in_r, win_rdy, lose_rdy;
        logic [3:0]  m;
        win = (v0 && !v1) ? 0 : ((!v0 && v1) ? 1 : ptr_m);
        got = 32'hx;
        acc_cyc = 0;
        req0_valid = v0;
        req1_valid = v1;
        #1;
        n = 0;
        win_rdy  = (win == 0) ? req0_ready : req1_ready;
        lose_rdy = (win == 0) ? req1_ready : req0_ready;
        while (!win_rdy) begin
            check("ready_loser_wait", 32'(lose_rdy), 32'd0);
            @(negedge clk);
            #1;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $error("FAIL accept_timeout: observed no grant for id %0d expected grant", win);
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                return;
            end
            win_rdy  = (win == 0) ? req0_ready : req1_ready;
            lose_rdy = (win == 0) ? req1_ready : req0_ready;
        end
        check("ready_loser", 32'(lose_rdy), 32'd0);
        acc_cyc = cyc;
        a = (win == 0) ? req0_addr  : req1_addr;
        w = (win == 0) ? req0_wen   : req1_wen;
        d = (win == 0) ? req0_wdata : req1_wdata;
        m = (win == 0) ? req0_wmask : req1_wmask;
        @(posedge clk);
        ptr_m  = 1 - win;
        in_r   = (a < 32'd64);
        idx    = int'(a[5:2]);
        exp_rd = (in_r && !w) ? ref_mem[idx] : 32'd0;
        if (in_r && w)
            for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        if (win == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        check("issue_mem_en", 32'(mem_en), 32'(in_r));
        check("issue_resp0", 32'(resp0_valid), 32'd0);
        check("issue_resp1", 32'(resp1_valid), 32'd0);
        if (in_r) begin
            check("issue_idx", 32'(mem_idx), 32'(idx));
            check("issue_wen", 32'(mem_wen), 32'(w));
            if (w) begin
                check("issue_wmask", 32'(mem_wmask), 32'(m));
                check("issue_wdata", mem_wdata, d);
            end
        end
        @(negedge clk);
        check("resp_mem_en", 32'(mem_en), 32'd0);
        check("resp_valid_win", 32'((win == 0) ? resp0_valid : resp1_valid), 32'd1);
        check("resp_valid_lose", 32'((win == 0) ? resp1_valid : resp0_valid), 32'd0);
        check("resp_err", 32'((win == 0) ? resp0_err : resp1_err), 32'(!in_r));
        got = (win == 0) ? resp0_rdata : resp1_rdata;
        check("resp_rdata", got, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          win, n;
        int unsigned acc, prev;
        logic [31:0] got;
        logic        ok;

        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1111_1111 * i;
        preload = 1'b1;
        set_req(0, 32'd0, 1'b0, 32'd0, 4'd0);
        set_req(1, 32'd0, 1'b0, 32'd0, 4'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        ptr_m = 0;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_resp0", 32'(resp0_valid), 32'd0);
        check("rst_resp1", 32'(resp1_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_idx", 32'(mem_idx), 32'd0);
        check("rst_rdata0", resp0_rdata, 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        reset = 1'b1;
        @(negedge clk);

        // Load of word 5 by the core.
        set_req(0, 32'h14, 1'b0, 32'd0, 4'd0);
        transact(1'b1, 1'b0, win, acc, got);
        check("load5_value", got, 32'h5555_5555);

        // Partial store by the debug port, then read back.
        set_req(1, 32'h08, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        transact(1'b0, 1'b1, win, acc, got);
        set_req(1, 32'h08, 1'b0, 32'd0, 4'd0);
        transact(1'b0, 1'b1, win, acc, got);
        check("partial_readback", got, 32'h2222_BEEF);

        // Out of range load.
        set_req(0, 32'h40, 1'b0, 32'd0, 4'd0);
        transact(1'b1, 1'b0, win, acc, got);
        check("oor_rdata", got, 32'd0);

        // Store with empty mask leaves the word intact.
        set_req(0, 32'h10, 1'b1, 32'hFFFF_FFFF, 4'b0000);
        transact(1'b1, 1'b0, win, acc, got);
        set_req(0, 32'h10, 1'b0, 32'd0, 4'd0);
        transact(1'b1, 1'b0, win, acc, got);
        check("zero_mask_word", got, 32'h4444_4444);

        // Round-robin with both requesters continuously valid from reset.
        do_reset();
        set_req(0, 32'h04, 1'b0, 32'd0, 4'd0);
        set_req(1, 32'h0C, 1'b0, 32'd0, 4'd0);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            transact(1'b1, 1'b1, win, acc, got);
            check("rr_grant_order", 32'(win), 32'(k % 2));
            if (k > 0) check("rr_spacing", acc - prev, 32'd3);
            prev = acc;
        end

        // Back-to-back core loads.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 32'(4 * (k + 6)), 1'b0, 32'd0, 4'd0);
            transact(1'b1, 1'b0, win, acc, got);
            if (k > 0) check("b2b_spacing", acc - prev, 32'd3);
            prev = acc;
        end

        // Reset during ISSUE discards the transaction and restores the pointer.
        set_req(0, 32'h0C, 1'b0, 32'd0, 4'd0);
        set_req(1, 32'h1C, 1'b0, 32'd0, 4'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req0_ready) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        check("rst_mid_grant", 32'(ok), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        check("rst_mid_pre_en", 32'(mem_en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_en_drop", 32'(mem_en), 32'd0);
        check("rst_mid_state", 32'(fsm_state), 32'(IDLE));
        ptr_m = 0;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (n == 1) reset = 1'b1;
            check("rst_mid_no_resp0", 32'(resp0_valid), 32'd0);
            check("rst_mid_no_resp1", 32'(resp1_valid), 32'd0);
            n++;
        end
        transact(1'b1, 1'b1, win, acc, got);
        check("rst_mid_first_winner", 32'(win), 32'd0);

        // Randomized mixed traffic from both ports.
        for (int k = 0; k < 60; k++) begin
            int  s;
            bit  v0, v1;
            s  = $urandom_range(1, 3);
            if (!req0_valid) rand_req(0);
            if (!req1_valid) rand_req(1);
            v0 = s[0] || req0_valid;
            v1 = s[1] || req1_valid;
            transact(v0, v1, win, acc, got);
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
